// File: rtl/wave_trace_render.sv
// Pixel-domain waveform renderer: draws a line-filled capture trace over a graticule
// and locks the capture RAM for the duration of each traced frame.
module wave_trace_render #(
  parameter int unsigned X_START      = 448,
  parameter int unsigned Y_TOP        = 200,
  parameter int unsigned GRID_SHIFT_X = 6,
  parameter int unsigned GRID_SHIFT_Y = 5,
  parameter logic [23:0] TRACE_COLOR  = 24'hFFFF00,
  parameter logic [23:0] GRID_COLOR   = 24'h404040,
  parameter logic [23:0] FRAME_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [11:0] pixel_xpos,
  input  logic [11:0] pixel_ypos,
  input  logic        buf_ready,
  output logic [9:0]  buf_rd_addr,
  input  logic [7:0]  buf_rd_data,
  output logic        buf_hold,
  output logic        buf_release,
  output logic [23:0] pixel_data
);

  localparam int unsigned COORD_W = 12;
  localparam int unsigned EXT_W   = COORD_W + 1;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned SAMP_W  = 8;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned WIN_W   = 1024;
  localparam int unsigned WIN_H   = 256;

  localparam logic [EXT_W-1:0] X_LO = EXT_W'(X_START);
  localparam logic [EXT_W-1:0] X_HI = EXT_W'(X_START + WIN_W - 1);
  localparam logic [EXT_W-1:0] Y_LO = EXT_W'(Y_TOP);
  localparam logic [EXT_W-1:0] Y_HI = EXT_W'(Y_TOP + WIN_H - 1);
  localparam logic [EXT_W-1:0] BX_L = EXT_W'(X_START - 1);
  localparam logic [EXT_W-1:0] BX_R = EXT_W'(X_START + WIN_W);
  localparam logic [EXT_W-1:0] BY_T = EXT_W'(Y_TOP - 1);
  localparam logic [EXT_W-1:0] BY_B = EXT_W'(Y_TOP + WIN_H);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DISPLAY,
    ST_RELEASE
  } lock_state_t;

  // Per-pixel attributes that travel alongside the RAM read.
  typedef struct packed {
    logic              in_win;
    logic              grid;
    logic              border;
    logic              trace_en;
    logic [SAMP_W-1:0] row;
  } px_tag_t;

  lock_state_t state_q, state_nxt;
  logic        hold_nxt, release_nxt, trace_en_c;

  logic [EXT_W-1:0]  x_ext, y_ext;
  logic [ADDR_W-1:0] col_c;
  logic [SAMP_W-1:0] row_c;
  logic              col_in_c, row_in_c, in_win_c, grid_c, border_c;
  logic              frame_start_c, last_px_c, first_col_c;
  px_tag_t           tag_c;

  px_tag_t           s0_q, s1_q, s2_q;
  logic              first_s0_q, first_s1_q;
  logic [SAMP_W-1:0] cur_q, prev_q;

  logic [SAMP_W-1:0] lvl_c, lo_c, hi_c;
  logic              trace_hit_c;
  logic [RGB_W-1:0]  color_c;

  // Stage-0 window, grid and border classification of the incoming coordinate.
  assign x_ext = {1'b0, pixel_xpos};
  assign y_ext = {1'b0, pixel_ypos};
  assign col_c = ADDR_W'(pixel_xpos - COORD_W'(X_START));
  assign row_c = SAMP_W'(pixel_ypos - COORD_W'(Y_TOP));

  assign col_in_c    = (x_ext >= X_LO) && (x_ext <= X_HI);
  assign row_in_c    = (y_ext >= Y_LO) && (y_ext <= Y_HI);
  assign in_win_c    = col_in_c && row_in_c;
  assign grid_c      = in_win_c && ((col_c[GRID_SHIFT_X-1:0] == '0) ||
                                    (row_c[GRID_SHIFT_Y-1:0] == '0));
  assign border_c    = (((x_ext == BX_L) || (x_ext == BX_R)) &&
                        (y_ext >= BY_T) && (y_ext <= BY_B)) ||
                       (((y_ext == BY_T) || (y_ext == BY_B)) &&
                        (x_ext >= BX_L) && (x_ext <= BX_R));
  assign first_col_c   = (x_ext == X_LO);
  assign frame_start_c = (pixel_xpos == '0) && (pixel_ypos == '0);
  assign last_px_c     = (x_ext == X_HI) && (y_ext == Y_HI);

  // Lock state register; hold/release are registered from the next state.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      buf_hold    <= 1'b0;
      buf_release <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      buf_hold    <= hold_nxt;
      buf_release <= release_nxt;
    end
  end

  // Lock next-state: trace is only enabled for frames entered at frame start.
  always_comb begin
    state_nxt   = state_q;
    trace_en_c  = 1'b0;
    hold_nxt    = 1'b0;
    release_nxt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (buf_ready) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!buf_ready) begin
          state_nxt = ST_IDLE;
        end else if (frame_start_c) begin
          state_nxt  = ST_DISPLAY;
          trace_en_c = 1'b1;
        end
      end
      ST_DISPLAY: begin
        trace_en_c = 1'b1;
        if (last_px_c) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    hold_nxt    = (state_nxt == ST_DISPLAY);
    release_nxt = (state_nxt == ST_RELEASE);
  end

  always_comb begin
    tag_c          = '0;
    tag_c.in_win   = in_win_c;
    tag_c.grid     = grid_c;
    tag_c.border   = border_c;
    tag_c.trace_en = trace_en_c;
    tag_c.row      = row_c;
  end

  // Stage 0 registers the tag and read address; stage 1 covers the RAM access.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      buf_rd_addr <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      first_s0_q  <= 1'b0;
      first_s1_q  <= 1'b0;
    end else begin
      buf_rd_addr <= col_in_c ? col_c : '0;
      s0_q        <= tag_c;
      first_s0_q  <= first_col_c;
      s1_q        <= s0_q;
      first_s1_q  <= first_s0_q;
    end
  end

  // Stage 2: sample arrives; prev is reloaded with the sample itself at column 0.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      cur_q  <= '0;
      prev_q <= '0;
      s2_q   <= '0;
    end else begin
      cur_q  <= buf_rd_data;
      prev_q <= first_s1_q ? buf_rd_data : cur_q;
      s2_q   <= s1_q;
    end
  end

  // Row 0 is the top of the window, so the level drawn there is 255.
  always_comb begin
    lvl_c       = ~s2_q.row;
    lo_c        = (prev_q < cur_q) ? prev_q : cur_q;
    hi_c        = (prev_q < cur_q) ? cur_q : prev_q;
    trace_hit_c = s2_q.in_win && s2_q.trace_en && (lvl_c >= lo_c) && (lvl_c <= hi_c);
    color_c     = BG_COLOR;
    if (trace_hit_c) begin
      color_c = TRACE_COLOR;
    end else if (s2_q.border) begin
      color_c = FRAME_COLOR;
    end else if (s2_q.grid) begin
      color_c = GRID_COLOR;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      pixel_data <= '0;
    end else begin
      pixel_data <= color_c;
    end
  end

endmodule

// File: tb/tb_wave_trace_render.sv
// Bench for wave_trace_render: random captures and scan rows, scoreboarded against
// a frame-level model of the lock handshake and the drawing rules.
module tb_wave_trace_render;

  localparam int X_START = 448;
  localparam int Y_TOP   = 200;
  localparam logic [23:0] TRACE_C = 24'hFFFF00;
  localparam logic [23:0] GRID_C  = 24'h404040;
  localparam logic [23:0] FRAME_C = 24'hFFFFFF;
  localparam logic [23:0] BG_C    = 24'h000000;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_xpos, pixel_ypos;
  logic        buf_ready;
  logic [9:0]  buf_rd_addr;
  logic [7:0]  buf_rd_data;
  logic        buf_hold, buf_release;
  logic [23:0] pixel_data;

  wave_trace_render #(.X_START(X_START), .Y_TOP(Y_TOP)) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .buf_ready   (buf_ready),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .buf_hold    (buf_hold),
    .buf_release (buf_release),
    .pixel_data  (pixel_data)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Capture RAM with a registered read port.
  logic [7:0] mem [1024];
  always @(posedge pixel_clk) buf_rd_data <= mem[buf_rd_addr];

  typedef struct { int edge_n; int x; int y; logic [23:0] px; } pix_exp_t;
  typedef struct { int edge_n; logic hold; logic rel; logic [9:0] addr; } ctl_exp_t;

  pix_exp_t pq[$];
  ctl_exp_t cq[$];
  int edge_cnt = 0;
  int checks   = 0;
  int errors   = 0;
  logic rst_val, ready_val;
  bit in_disp;
  int ready_run;
  int rows[$];

  function automatic logic [23:0] exp_px(input int x, input int y, input bit trace_on);
    int col, row, cur, prev, lvl, lo, hi;
    bit in_win, border;
    col = x - X_START;
    row = y - Y_TOP;
    in_win = (col >= 0) && (col < 1024) && (row >= 0) && (row < 256);
    border = (((x == X_START - 1) || (x == X_START + 1024)) && (y >= Y_TOP - 1) && (y <= Y_TOP + 256)) ||
             (((y == Y_TOP - 1) || (y == Y_TOP + 256)) && (x >= X_START - 1) && (x <= X_START + 1024));
    if (in_win && trace_on) begin
      cur  = int'(mem[10'(col)]);
      prev = (col == 0) ? cur : int'(mem[10'(col - 1)]);
      lvl  = 255 - row;
      lo   = (prev < cur) ? prev : cur;
      hi   = (prev < cur) ? cur : prev;
      if (lvl >= lo && lvl <= hi) return TRACE_C;
    end
    if (border) return FRAME_C;
    if (in_win && (((col % 64) == 0) || ((row % 32) == 0))) return GRID_C;
    return BG_C;
  endfunction

  // Issue one coordinate and push what the DUT must produce for it.
  task automatic drive(input int x, input int y);
    pix_exp_t p;
    ctl_exp_t c;
    bit fs, last, trace_on;
    int col;
    @(negedge pixel_clk);
    pixel_xpos = 12'(x);
    pixel_ypos = 12'(y);
    buf_ready  = ready_val;
    if (rst_val && !rst) begin
      rst = 1'b1;
      foreach (pq[i]) pq[i].px = '0;
      in_disp   = 0;
      ready_run = 0;
      #1;
      checks++;
      if (buf_hold !== 1'b0 || buf_release !== 1'b0 || pixel_data !== 24'h0 || buf_rd_addr !== 10'h0) begin
        errors++;
        $display("FAIL async_reset: hold=%b rel=%b px=%h addr=%0d, required all zero",
                 buf_hold, buf_release, pixel_data, buf_rd_addr);
      end
    end else begin
      rst = rst_val;
    end
    p.edge_n = edge_cnt + 1;
    c.edge_n = p.edge_n;
    p.x = x;
    p.y = y;
    if (rst) begin
      in_disp   = 0;
      ready_run = 0;
      p.px   = '0;
      c.hold = 1'b0;
      c.rel  = 1'b0;
      c.addr = '0;
    end else begin
      fs   = (x == 0) && (y == 0);
      last = (x == X_START + 1023) && (y == Y_TOP + 255);
      if (!in_disp && fs && buf_ready && ready_run >= 1) in_disp = 1;
      trace_on = in_disp;
      c.rel = in_disp && last;
      if (last) in_disp = 0;
      c.hold = in_disp;
      ready_run = buf_ready ? ready_run + 1 : 0;
      col = x - X_START;
      c.addr = (col >= 0 && col < 1024) ? 10'(col) : 10'h0;
      p.px = exp_px(x, y, trace_on);
    end
    pq.push_back(p);
    cq.push_back(c);
  endtask

  // Event kinds: 1 raise buf_ready, 2 drop buf_ready, 3 reset pulse.
  task automatic apply_event(input int kind, input int y);
    if (kind == 1) ready_val = 1'b1;
    if (kind == 2) ready_val = 1'b0;
    if (kind == 3) begin
      rst_val = 1'b1;
      repeat (3) drive(X_START + 5, y);
      rst_val = 1'b0;
    end
  endtask

  task automatic run_frame(input bit fs_ready, input int ev_a_idx, input int ev_a_kind,
                           input int ev_b_idx, input int ev_b_kind);
    if (fs_ready) ready_val = 1'b1;
    drive(0, 0);
    drive(1, 0);
    drive(2, 0);
    rows.sort();
    for (int i = 0; i < rows.size(); i++) begin
      if (i == ev_a_idx) apply_event(ev_a_kind, rows[i]);
      if (i == ev_b_idx) apply_event(ev_b_kind, rows[i]);
      for (int x = X_START - 2; x <= X_START + 1025; x++) drive(x, rows[i]);
    end
    repeat (8) drive(3, 1);
    rows.delete();
  endtask

  task automatic add_random_rows(input int n);
    for (int i = 0; i < n; i++) rows.push_back(Y_TOP + int'($urandom_range(0, 255)));
  endtask

  // Monitor: compares outputs against the scoreboard at the cycle they are due.
  initial begin
    pix_exp_t p;
    ctl_exp_t c;
    forever begin
      @(posedge pixel_clk);
      edge_cnt++;
      #1;
      while (pq.size() > 0 && pq[0].edge_n + 3 <= edge_cnt) begin
        p = pq.pop_front();
        checks++;
        if (p.edge_n + 3 != edge_cnt || pixel_data !== p.px) begin
          errors++;
          $display("FAIL pixel (%0d,%0d) edge %0d: got %h, required %h",
                   p.x, p.y, edge_cnt, pixel_data, p.px);
        end
      end
      while (cq.size() > 0 && cq[0].edge_n <= edge_cnt) begin
        c = cq.pop_front();
        checks++;
        if (buf_hold !== c.hold || buf_release !== c.rel || buf_rd_addr !== c.addr) begin
          errors++;
          $display("FAIL ctl edge %0d: hold/rel/addr got %b/%b/%0d, required %b/%b/%0d",
                   edge_cnt, buf_hold, buf_release, buf_rd_addr, c.hold, c.rel, c.addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    rst_val    = 1'b1;
    ready_val  = 1'b0;
    buf_ready  = 1'b0;
    pixel_xpos = '0;
    pixel_ypos = '0;
    in_disp    = 0;
    ready_run  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

    // Scan under reset, then release without buf_ready: graticule only.
    for (int x = X_START - 4; x < X_START + 12; x++) drive(x, Y_TOP);
    rst_val = 1'b0;
    rows = '{Y_TOP - 1, Y_TOP, Y_TOP + 32, Y_TOP + 255, Y_TOP + 256};
    add_random_rows(1);
    run_frame(0, -1, 0, -1, 0);

    // Constant mid-level capture; buf_ready raised mid-frame, next frame locks.
    for (int i = 0; i < 1024; i++) mem[i] = 8'd128;
    rows = '{Y_TOP, Y_TOP + 100, Y_TOP + 255};
    run_frame(0, 1, 1, -1, 0);
    rows = '{Y_TOP - 1, Y_TOP + 126, Y_TOP + 127, Y_TOP + 128, Y_TOP + 255};
    add_random_rows(1);
    run_frame(0, 2, 2, -1, 0);

    // buf_ready pulses while armed, then rises exactly at frame start: no lock.
    rows = '{Y_TOP, Y_TOP + 100, Y_TOP + 255};
    run_frame(0, 0, 1, 1, 2);
    rows = '{Y_TOP + 64, Y_TOP + 255};
    run_frame(1, -1, 0, -1, 0);

    // Step capture in a locked frame.
    for (int i = 0; i < 1024; i++) mem[i] = (i <= 100) ? 8'd0 : 8'd255;
    rows = '{Y_TOP, Y_TOP + 255};
    add_random_rows(2);
    run_frame(0, -1, 0, -1, 0);

    // Random capture; reset during the locked frame, then a fresh lock.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    rows = '{Y_TOP, Y_TOP + 200, Y_TOP + 255};
    add_random_rows(2);
    run_frame(0, 2, 3, -1, 0);
    rows = '{Y_TOP, Y_TOP + 255};
    add_random_rows(1);
    run_frame(0, -1, 0, -1, 0);

    // buf_ready low for a whole frame: no trace.
    ready_val = 1'b0;
    rows = '{Y_TOP + 30, Y_TOP + 255};
    run_frame(0, -1, 0, -1, 0);

    repeat (6) @(negedge pixel_clk);
    checks++;
    if (pq.size() != 0 || cq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pixel and %0d ctl expectations left, required 0", pq.size(), cq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_trace_render.md
# wave_trace_render

Pixel-domain waveform renderer for the HDMI oscilloscope path. It sits between the 1024×8 dual-clock capture RAM and the video driver. The block reads captured ADC samples in step with the scan position and draws a line-filled yellow trace over a graticule. A buffer-lock handshake with the capture sampler keeps the sampler from overwriting the RAM while a frame is being drawn.

## Interface

Parameters:
- X_START, 448: first pixel column of the plot window; the window is 1024 columns wide, one sample per column.
- Y_TOP, 200: first pixel row of the plot window; the window is 256 rows tall.
- GRID_SHIFT_X, 6: vertical grid line every 2^6 = 64 columns.
- GRID_SHIFT_Y, 5: horizontal grid line every 2^5 = 32 rows.
- TRACE_COLOR, 24'hFFFF00 · GRID_COLOR, 24'h404040 · FRAME_COLOR, 24'hFFFFFF · BG_COLOR, 24'h000000.

Ports:
- pixel_clk  in  1  pixel clock; the single clock of the block.
- rst  in  1  reset, asynchronous, active-high.
- pixel_xpos  in  12  scan column from the video driver.
- pixel_ypos  in  12  scan row from the video driver.
- buf_ready  in  1  level from the capture sampler: the RAM holds a complete capture.
- buf_rd_addr  out  10  capture RAM read address; the RAM has a registered output with 1-cycle read latency.
- buf_rd_data  in  8  capture RAM read data.
- buf_hold  out  1  level: the RAM is locked for display; the sampler must not write while this is high.
- buf_release  out  1  one-cycle pulse: the frame is finished and the sampler may recapture.
- pixel_data  out  24  RGB888 to the video driver.

## Operation

- Window membership, evaluated at stage 0:
  - col = xpos − X_START, row = ypos − Y_TOP.
  - in_win = (0 ≤ col ≤ 1023) && (0 ≤ row ≤ 255).
- Read address: buf_rd_addr = col[9:0] when xpos is inside the column range, else 0.
- Sample mapping: level L = 255 − row, so sample 255 draws on the top row and sample 0 on the bottom row.
- Line fill:
  - cur = sample for this column; prev = sample for the previous column of the same line.
  - At col 0, prev = cur.
  - A pixel is trace when in_win, the lock is valid, and min(prev,cur) ≤ L ≤ max(prev,cur). Unsigned 8-bit compares.
- Grid: a pixel is grid when in_win and either col[GRID_SHIFT_X−1:0] == 0 or row[GRID_SHIFT_Y−1:0] == 0.
- Border: a pixel is border on column X_START−1 or X_START+1024 for rows Y_TOP−1..Y_TOP+256. It is also border on row Y_TOP−1 or Y_TOP+256 for the same column span.
- Color priority: trace > border > grid > BG_COLOR.
- Lock state machine:
  - IDLE: buf_hold = 0. If buf_ready = 1, go to ARMED.
  - ARMED: buf_hold = 0. At frame start (xpos == 0 && ypos == 0), go to DISPLAY and set buf_hold = 1 in the same cycle.
  - DISPLAY: buf_hold = 1; the trace is enabled. After the last window pixel (col 1023, row 255) has been issued, go to RELEASE.
  - RELEASE: buf_release = 1 for exactly one cycle, buf_hold = 0, then go to IDLE.
- Trace enable applies only to frames that enter DISPLAY at frame start. All other frames draw grid and border only.
- If buf_ready drops while in ARMED, return to IDLE. In DISPLAY, buf_ready is ignored until RELEASE.
- Reset, including mid-frame: state = IDLE, all pipeline registers clear. Rendering resumes with grid only; the trace returns only after a fresh ARMED → DISPLAY transition.

## Timing

- Reset values: pixel_data = 0, buf_rd_addr = 0, buf_hold = 0, buf_release = 0.
- Pipeline, with fixed latency of 3 pixel_clk from coordinates to pixel_data:
  - Stage 0: register coordinates, flags, and buf_rd_addr.
  - Stage 1: RAM access.
  - Stage 2: buf_rd_data valid; update prev/cur.
  - Stage 3: register pixel_data.
- The video driver compensates for the 3-cycle latency by issuing coordinates 3 cycles ahead.
- Flags and row travel with the pipeline, so the color decision uses the coordinates that produced the sample.
- prev is the cur of the preceding column from the same line. It is reloaded at col 0 on every row.
- buf_hold rises in the frame-start cycle and stays high until the RELEASE cycle.
- buf_release fires 1 cycle after the stage-0 cycle of (col 1023, row 255).
- Frame start and buf_ready rising in the same cycle while in IDLE: go to ARMED only. DISPLAY waits for the next frame start.

## Test plan

- Reset: hold rst high during a scan; pixel_data = 0, buf_hold = 0. Release rst without buf_ready: only grid and border appear, for example (X_START, Y_TOP) = 404040 and (X_START−1, Y_TOP) = FFFFFF.
- Constant 128 in all RAM words, buf_ready = 1: the frame after the lock shows FFFF00 only on row Y_TOP+127 across all 1024 columns. Output appears exactly 3 cycles after the coordinates.
- Step: samples 0 for columns 0..100 and 255 for columns 101..1023. Column 101 is trace on all 256 rows; column 100 is trace only on row Y_TOP+255.
- Handshake: assert buf_ready mid-frame. buf_hold rises at the next (0,0), and buf_release pulses once, 1 cycle after the stage-0 cycle of (X_START+1023, Y_TOP+255). buf_hold falls in the same cycle as the pulse.
- Lock gating: with buf_ready = 0, no FFFF00 pixel appears for a full frame.
- Mid-frame reset during DISPLAY: buf_hold drops immediately and no buf_release pulse occurs. The trace is absent until the next lock.
